// File: rtl/prewish_pkg.sv
// Shared definitions for the prewish bus arbiters: FSM state encoding,
// requester limit and data width.
package prewish_pkg;

    // Largest requester count any prewish arbiter supports.
    localparam int PREWISH_MAX_REQ = 4;

    // Width of the pattern-load data bus into prewish_blinky.
    localparam int PREWISH_DAT_W = 8;

    // Width of a requester index / round-robin pointer.
    localparam int PREWISH_IDX_W = $clog2(PREWISH_MAX_REQ);

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_HOLD  = 2'd2
    } prewish_arb_state_t;

endpackage : prewish_pkg

// File: rtl/prewish_rr_pick.sv
// Combinational round-robin picker. The search starts at pointer ptr and
// walks upward modulo NUM_REQ; the first asserted request wins. ptr must be
// below NUM_REQ (larger values are never produced by the arbiters).
module prewish_rr_pick
    import prewish_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]       req,
    input  logic [PREWISH_IDX_W-1:0] ptr,
    output logic                     valid,
    output logic [PREWISH_IDX_W-1:0] idx
);

    logic [PREWISH_MAX_REQ-1:0] req_ext;
    logic [PREWISH_IDX_W:0]     pos;

    assign req_ext = PREWISH_MAX_REQ'(req);

    // Scan from the farthest offset down to offset 0 so the closest
    // asserted request to the pointer is the one left in idx.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (PREWISH_IDX_W + 1)'(k);
            if (pos >= (PREWISH_IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (PREWISH_IDX_W + 1)'(NUM_REQ);
            end
            if (req_ext[pos[PREWISH_IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[PREWISH_IDX_W-1:0];
            end
        end
    end

endmodule : prewish_rr_pick

// File: rtl/prewish_strobe_arb.sv
// Arbiter sharing the prewish_blinky pattern-load bus (STB + 8-bit DAT)
// between NUM_REQ requesters. Each grant becomes a one-cycle strobe followed
// by HOLDOFF_CYCLES idle cycles during which all requests are ignored.
//
// Handshake: a requester holds STB_I[n] high with stable DAT_I[n] until it
// sees its one-cycle ACK_O[n]; that ACK coincides with STB_O carrying its
// data. A request dropped before the arbiter samples it in IDLE is simply
// never granted.
//
// Build option: define PREWISH_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 highest, pointer tied to 0); otherwise round-robin.
// DBG_STATE_O exposes the FSM state for observation.
module prewish_strobe_arb
    import prewish_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic                               CLK_I,
    input  logic                               RST_N_I,
    input  logic [NUM_REQ-1:0]                 STB_I,
    input  logic [PREWISH_DAT_W*NUM_REQ-1:0]   DAT_I,
    output logic [NUM_REQ-1:0]                 ACK_O,
    output logic                               STB_O,
    output logic [PREWISH_DAT_W-1:0]           DAT_O,
    output logic [1:0]                         GNT_O,
    output logic                               BUSY_O,
    output prewish_arb_state_t                 DBG_STATE_O
);

    localparam int CNT_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);

    prewish_arb_state_t              state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            stb_d;
    logic [NUM_REQ-1:0]              ack_d;
    logic [PREWISH_DAT_W-1:0]        dat_d;
    logic [1:0]                      gnt_d;
    logic [PREWISH_IDX_W-1:0]        ptr_q;
    logic                            pick_valid;
    logic [PREWISH_IDX_W-1:0]        pick_idx;
    logic [PREWISH_MAX_REQ-1:0]      ack_full;
    logic [PREWISH_DAT_W*PREWISH_MAX_REQ-1:0] dat_ext;
    logic [PREWISH_DAT_W-1:0]        dat_sel;

    prewish_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (STB_I),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Winner's data and one-hot ACK, derived from the picked index.
    assign dat_ext  = (PREWISH_DAT_W * PREWISH_MAX_REQ)'(DAT_I);
    assign dat_sel  = dat_ext[{pick_idx, 3'b000} +: PREWISH_DAT_W];
    assign ack_full = PREWISH_MAX_REQ'(1) << pick_idx;

`ifdef PREWISH_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign ptr_q = '0;
`else
    logic [PREWISH_IDX_W-1:0] ptr_d;

    // Advance the pointer past the winner on every grant issued from IDLE.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && pick_valid) begin
            if (pick_idx == PREWISH_IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + PREWISH_IDX_W'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stb_d   = 1'b0;
        ack_d   = '0;
        dat_d   = DAT_O;
        gnt_d   = GNT_O;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    stb_d   = 1'b1;
                    ack_d   = ack_full[NUM_REQ-1:0];
                    dat_d   = dat_sel;
                    gnt_d   = 2'(pick_idx);
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                cnt_d   = HOLD_LOAD;
                state_d = (HOLDOFF_CYCLES == 0) ? ARB_IDLE : ARB_HOLD;
            end
            ARB_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, counter and output registers; all cleared asynchronously.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            STB_O   <= 1'b0;
            ACK_O   <= '0;
            DAT_O   <= '0;
            GNT_O   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            STB_O   <= stb_d;
            ACK_O   <= ack_d;
            DAT_O   <= dat_d;
            GNT_O   <= gnt_d;
        end
    end

    assign BUSY_O      = (state_q != ARB_IDLE);
    assign DBG_STATE_O = state_q;

endmodule : prewish_strobe_arb

// File: tb/tb_prewish_strobe_arb.sv
// Directed bench for prewish_strobe_arb: one instance with the default
// holdoff of 8, one with holdoff 0. Expected values are hand-derived.
module tb_prewish_strobe_arb;
    import prewish_pkg::*;

`ifdef PREWISH_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;

    logic [1:0]         stb_i = '0;
    logic [15:0]        dat_i = '0;
    logic [1:0]         ack_o;
    logic               stb_o;
    logic [7:0]         dat_o;
    logic [1:0]         gnt_o;
    logic               busy_o;
    prewish_arb_state_t st_o;

    logic [1:0]         stb_z = '0;
    logic [15:0]        dat_z = '0;
    logic [1:0]         ack_z;
    logic               stbo_z;
    logic [7:0]         dato_z;
    logic [1:0]         gnt_z;
    logic               busy_z;
    prewish_arb_state_t st_z;

    int checks = 0;
    int errors = 0;

    // Clock and reset block.
    always #5 clk = ~clk;

    prewish_strobe_arb #(.NUM_REQ(2), .HOLDOFF_CYCLES(8)) u_dut (
        .CLK_I(clk), .RST_N_I(rst_n), .STB_I(stb_i), .DAT_I(dat_i),
        .ACK_O(ack_o), .STB_O(stb_o), .DAT_O(dat_o), .GNT_O(gnt_o),
        .BUSY_O(busy_o), .DBG_STATE_O(st_o)
    );

    prewish_strobe_arb #(.NUM_REQ(2), .HOLDOFF_CYCLES(0)) u_dut_z (
        .CLK_I(clk), .RST_N_I(rst_n), .STB_I(stb_z), .DAT_I(dat_z),
        .ACK_O(ack_z), .STB_O(stbo_z), .DAT_O(dato_z), .GNT_O(gnt_z),
        .BUSY_O(busy_z), .DBG_STATE_O(st_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        int busy_cnt;
        int stb_cnt;
        int ack1_cnt;
        int w;
        bit found;
        logic [7:0] exp_d[5];
        logic [1:0] exp_g[5];

        // Reset state.
        @(negedge clk);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_dat", 32'(dat_o), 32'h00);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_state", 32'(st_o), 32'(ARB_IDLE));
        check("rst_z_stb", 32'(stbo_z), 32'd0);

        // Holdoff-zero instance, both requesters held: strobe every 2 cycles.
        rst_n = 1'b1;
        stb_z = 2'b11;
        dat_z = 16'h2211;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("z_stb", 32'(stbo_z), 32'(c % 2));
            if (c % 2 == 1) begin
                w = FIXED ? 0 : ((c - 1) / 2) % 2;
                check("z_dat", 32'(dato_z), (w == 0) ? 32'h11 : 32'h22);
                check("z_ack", 32'(ack_z), 32'(1 << w));
                check("z_gnt", 32'(gnt_z), 32'(w));
            end else begin
                check("z_ack_idle", 32'(ack_z), 32'd0);
            end
        end
        stb_z = 2'b00;

        // Single request from requester 0.
        @(negedge clk);
        stb_i = 2'b01;
        dat_i = 16'h00A5;
        @(negedge clk);
        check("single_stb", 32'(stb_o), 32'd1);
        check("single_dat", 32'(dat_o), 32'hA5);
        check("single_ack", 32'(ack_o), 32'b01);
        check("single_gnt", 32'(gnt_o), 32'd0);
        stb_i = 2'b00;
        busy_cnt = int'(busy_o);
        stb_cnt = int'(stb_o);
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            busy_cnt += int'(busy_o);
            stb_cnt += int'(stb_o);
        end
        check("single_busy_len", 32'(busy_cnt), 32'd9);
        check("single_stb_count", 32'(stb_cnt), 32'd1);
        check("single_dat_hold", 32'(dat_o), 32'hA5);

        // Both held continuously; pointer now at 1 in round-robin.
        for (int i = 0; i < 5; i++) begin
            if (FIXED) begin
                exp_d[i] = 8'h11;
                exp_g[i] = 2'd0;
            end else begin
                exp_d[i] = (i % 2 == 0) ? 8'h22 : 8'h11;
                exp_g[i] = (i % 2 == 0) ? 2'd1 : 2'd0;
            end
        end
        @(negedge clk);
        stb_i = 2'b11;
        dat_i = 16'h2211;
        k = 0;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (stb_o) begin
                if (k < 5) begin
                    check("sim_cycle", 32'(c), 32'(1 + 10 * k));
                    check("sim_dat", 32'(dat_o), 32'(exp_d[k]));
                    check("sim_gnt", 32'(gnt_o), 32'(exp_g[k]));
                    check("sim_ack", 32'(ack_o), 32'(2'b01 << exp_g[k]));
                end
                k++;
            end
        end
        check("sim_count", 32'(k), 32'd5);

        // Requester 0 drops; requester 1 must be served next.
        stb_i = 2'b10;
        found = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (stb_o && !found) begin
                found = 1'b1;
                check("drop0_dat", 32'(dat_o), 32'h22);
                check("drop0_gnt", 32'(gnt_o), 32'd1);
                stb_i = 2'b00;
            end
        end
        check("drop0_found", 32'(found), 32'd1);
        stb_i = 2'b00;
        repeat (10) @(negedge clk);
        check("idle_before_withdraw", 32'(busy_o), 32'd0);

        // Withdraw: requester 1 requests only inside HOLD.
        stb_i = 2'b01;
        dat_i = 16'h775A;
        @(negedge clk);
        check("wd_stb", 32'(stb_o), 32'd1);
        check("wd_dat", 32'(dat_o), 32'h5A);
        stb_i = 2'b00;
        stb_cnt = 0;
        ack1_cnt = 0;
        for (int c = 2; c <= 15; c++) begin
            @(negedge clk);
            if (c == 3) stb_i = 2'b10;
            if (c == 6) stb_i = 2'b00;
            stb_cnt += int'(stb_o);
            ack1_cnt += int'(ack_o[1]);
        end
        check("wd_no_stb", 32'(stb_cnt), 32'd0);
        check("wd_no_ack1", 32'(ack1_cnt), 32'd0);

        // Reset mid-HOLD, then requester 1 pending after release.
        stb_i = 2'b01;
        dat_i = 16'hC35A;
        @(negedge clk);
        check("mr_stb", 32'(stb_o), 32'd1);
        stb_i = 2'b00;
        repeat (3) @(negedge clk);
        check("mr_busy_pre", 32'(busy_o), 32'd1);
        stb_i = 2'b10;
        #2 rst_n = 1'b0;
        #1;
        check("mr_stb0", 32'(stb_o), 32'd0);
        check("mr_ack0", 32'(ack_o), 32'd0);
        check("mr_dat0", 32'(dat_o), 32'h00);
        check("mr_gnt0", 32'(gnt_o), 32'd0);
        check("mr_busy0", 32'(busy_o), 32'd0);
        check("mr_state0", 32'(st_o), 32'(ARB_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_post_stb", 32'(stb_o), 32'd1);
        check("mr_post_ack", 32'(ack_o), 32'b10);
        check("mr_post_gnt", 32'(gnt_o), 32'd1);
        check("mr_post_dat", 32'(dat_o), 32'hC3);
        stb_i = 2'b00;
        @(negedge clk);
        check("mr_post_stb_off", 32'(stb_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prewish_strobe_arb

// File: doc/prewish_strobe_arb.md
# prewish_strobe_arb

Arbiter sharing the single pattern-load bus of `prewish_blinky` (STB + 8-bit DAT) between up to four requesters, e.g. `prewish_mentor` plus a button/debug source. It sits between the requesters and `prewish_blinky`, clocked by the `prewish_syscon` system clock. Each request is granted round-robin and issued as a one-cycle strobe. A programmable holdoff window follows each strobe so blinky sees spaced-out loads.

## Interface
- `NUM_REQ`, default 2; number of requesters, legal range 2..4.
- `HOLDOFF_CYCLES`, default 8; idle cycles forced after each issued strobe, legal range 0..65535.
- `CLK_I`  in  1  system clock (from `prewish_syscon` CLK_O); one clock domain only.
- `RST_N_I`  in  1  reset, asynchronous assert, active-low; all state is cleared while low.
- `STB_I`  in  NUM_REQ  per-requester request; level, held until that requester's ACK.
- `DAT_I`  in  8*NUM_REQ  requester n data on bits [8n+7:8n]; must be stable while STB_I[n] is high.
- `ACK_O`  out  NUM_REQ  one-cycle grant/accept pulse to the winning requester.
- `STB_O`  out  1  one-cycle strobe to blinky STB_I.
- `DAT_O`  out  8  data to blinky DAT_I; registered, holds last issued value.
- `GNT_O`  out  2  index of last granted requester.
- `BUSY_O`  out  1  high in GRANT and HOLD states.

## Operation
- States: IDLE, GRANT, HOLD.
- IDLE:
  - If any STB_I bit is high, pick a winner w.
  - Register DAT_O <= DAT_I[w], GNT_O <= w, STB_O <= 1, ACK_O[w] <= 1.
  - Go to GRANT.
- GRANT (exactly 1 cycle):
  - STB_O and ACK_O[w] are high for this cycle only.
  - Load the holdoff counter with HOLDOFF_CYCLES.
  - Go to HOLD, or to IDLE if HOLDOFF_CYCLES = 0.
- HOLD:
  - Decrement the counter each cycle.
  - All STB_I inputs are ignored.
  - When the counter reaches 1, go to IDLE on the next edge.
- Round-robin:
  - Pointer p, reset 0.
  - Search order is p, p+1, … mod NUM_REQ; the first asserted request wins.
  - After a grant, p <= (w+1) mod NUM_REQ.
- A request withdrawn before it is sampled in IDLE is never granted, and no ACK is issued.
- STB_I bits with index >= NUM_REQ do not exist. Out-of-range pointer values are unreachable.
- Counter width: $clog2(HOLDOFF_CYCLES+1), minimum 1 bit. No wrap; the counter saturates at 0.
- Reset values: STB_O=0, ACK_O=0, DAT_O=8'h00, GNT_O=0, BUSY_O=0, state=IDLE, p=0, counter=0.
- Reset mid-operation (GRANT or HOLD): outputs return to reset values immediately (asynchronous). Any in-flight grant is lost. The requester must re-request.

## Timing
- Request sampled in IDLE at edge t: STB_O/ACK_O high during cycle t+1.
- Requesters deassert STB_I from cycle t+2 after seeing ACK (registered requester); the arbiter never double-grants.
- Next possible sample: edge t+2+HOLDOFF_CYCLES. Minimum strobe spacing is HOLDOFF_CYCLES+2 cycles.
- Latency from request to strobe: 1 cycle best case. Worst case is (NUM_REQ-1)*(HOLDOFF_CYCLES+2)+1 cycles with all requesters busy.
- DAT_O changes only on the edge that raises STB_O.

## Configuration
- `PREWISH_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; requester 0 is highest.
  - p is held at 0 and the pointer update is removed.
- Not defined: round-robin as above.
- Timing and handshake are identical in both builds.

## Structure
- Shared package `prewish_pkg`:
  - state typedef `prewish_arb_state_t` (IDLE/GRANT/HOLD).
  - `PREWISH_MAX_REQ` = 4.
  - `PREWISH_DAT_W` = 8.
- One natural sub-module, `prewish_rr_pick`: combinational, takes the request vector and pointer p, returns valid + winner index. It is reused by future bus arbiters.
- Counter and FSM stay in the top module.

## Test plan
- Single request: STB_I=2'b01, DAT_I[7:0]=8'hA5 -> one cycle later STB_O=1, DAT_O=8'hA5, ACK_O=2'b01, GNT_O=0, all for 1 cycle; BUSY_O high for 1+8 cycles.
- Simultaneous: both held continuously, data 8'h11/8'h22, HOLDOFF_CYCLES=8 -> strobes carry 11, 22, 11, 22… spaced exactly 10 cycles apart.
- Holdoff zero: HOLDOFF_CYCLES=0, both requesting -> strobes every 2 cycles alternating; never two ACKs to the same requester for one request.
- Withdraw: requester 1 raises STB_I during HOLD and drops it before HOLD ends -> no ACK_O[1], no strobe.
- Reset mid-HOLD: assert RST_N_I low 3 cycles into HOLD -> all outputs 0 asynchronously. After release with requester 1 pending, requester 1 is granted first (p=0, requester 0 idle), 1 cycle after the first sampling edge.
- `PREWISH_ARB_FIXED_PRIO_EN` build: both held continuously -> only requester 0 is ever granted; requester 1 is granted only after requester 0 drops.
